// File: rtl/csi2tx_yuv420_p2b_gen.sv
// YUV420 pixel-to-byte packer for the CSI-2 TX pixel path.
// Turns one pixel per cycle into a little-endian byte stream, packed into
// DW_BYTES-wide words, with a byte-enabled partial flush at line end.
module csi2tx_yuv420_p2b_gen #(
    parameter int unsigned DW_BYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           pixel_data,
    input  logic                  pixel_data_vld,
    input  logic                  line_start,
    input  logic                  line_end,
    input  logic                  line_odd,
    input  logic                  mode,
    input  logic                  convrn_enable,
    output logic [8*DW_BYTES-1:0] dw,
    output logic                  dw_vld,
    output logic [DW_BYTES-1:0]   dw_be,
    output logic                  dw_last,
    output logic                  protocol_err
);

    localparam int unsigned AW = 8 * (DW_BYTES + 1);
    localparam int unsigned WW = 8 * DW_BYTES;
    localparam int unsigned FW = $clog2(DW_BYTES + 2);
    localparam logic [FW-1:0] DW_FILL = FW'(DW_BYTES);

    typedef enum logic [1:0] {StIdle, StActive, StFlush} state_e;

    state_e state_q, state_d;

    // Accumulator keeps every byte at or above fill_q at zero, so a flush
    // can present the low lanes directly.
    logic [AW-1:0]       acc_q, acc_d, acc_app;
    logic [FW-1:0]       fill_q, fill_d, fill_app;
    logic                par_q, par_d, par_base;

    logic [WW-1:0]       dw_d;
    logic                vld_d, last_d, err_d;
    logic [DW_BYTES-1:0] be_d;

    logic [7:0]          y_b, u_b, v_b, b0, b1;
    logic                two_b;
    logic [15:0]         new_bytes;
    logic [FW-1:0]       nbytes;
    logic                unused_bits;

    assign y_b = pixel_data[27:20];
    assign u_b = pixel_data[17:10];
    assign v_b = pixel_data[7:0];
    assign unused_bits = ^{pixel_data[31:28], pixel_data[19:18], pixel_data[9:8]};

    // A line_start in the same cycle restarts parity before the pixel is used.
    assign par_base  = line_start ? 1'b0 : par_q;
    assign new_bytes = two_b ? {b1, b0} : {8'h00, b0};
    assign nbytes    = two_b ? FW'(2) : FW'(1);

    // Pick the chroma/luma bytes this pixel contributes; chroma goes first.
    always_comb begin
        b0    = y_b;
        b1    = y_b;
        two_b = 1'b0;
        if (!mode) begin
            if (!par_base) begin
                two_b = 1'b1;
                b0    = line_odd ? u_b : v_b;
            end
        end else if (!line_odd) begin
            two_b = 1'b1;
            b0    = par_base ? v_b : u_b;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        if (!convrn_enable) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:   if (line_start || pixel_data_vld) state_d = StActive;
                StActive: if (line_end) state_d = StFlush;
                StFlush:  state_d = StIdle;
                default:  state_d = StIdle;
            endcase
        end
    end

    // Accumulator update and next values of the registered outputs.
    always_comb begin
        acc_d    = acc_q;
        fill_d   = fill_q;
        par_d    = par_q;
        acc_app  = '0;
        fill_app = '0;
        dw_d     = '0;
        vld_d    = 1'b0;
        be_d     = '0;
        last_d   = 1'b0;
        err_d    = 1'b0;
        if (!convrn_enable) begin
            acc_d  = '0;
            fill_d = '0;
            par_d  = 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StActive: begin
                    err_d    = (state_q == StIdle && line_end) ||
                               (state_q == StActive && line_start);
                    acc_app  = line_start ? '0 : acc_q;
                    fill_app = line_start ? '0 : fill_q;
                    par_d    = par_base;
                    if (pixel_data_vld) begin
                        acc_app  = acc_app | (AW'(new_bytes) << {fill_app, 3'b000});
                        fill_app = fill_app + nbytes;
                        par_d    = ~par_base;
                    end
                    if (fill_app >= DW_FILL) begin
                        dw_d   = acc_app[WW-1:0];
                        vld_d  = 1'b1;
                        be_d   = '1;
                        acc_d  = acc_app >> WW;
                        fill_d = fill_app - DW_FILL;
                        // A word that exactly ends the line is itself the last word.
                        last_d = (state_q == StActive) && line_end && (fill_d == '0);
                    end else begin
                        acc_d  = acc_app;
                        fill_d = fill_app;
                    end
                end
                StFlush: begin
                    err_d = pixel_data_vld || line_start;
                    if (fill_q != '0) begin
                        dw_d   = acc_q[WW-1:0];
                        vld_d  = 1'b1;
                        last_d = 1'b1;
                        for (int unsigned k = 0; k < DW_BYTES; k++) begin
                            be_d[k] = (FW'(k) < fill_q);
                        end
                    end
                    acc_d  = '0;
                    fill_d = '0;
                    par_d  = 1'b0;
                end
                default: begin
                    acc_d  = '0;
                    fill_d = '0;
                    par_d  = 1'b0;
                end
            endcase
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q        <= '0;
            fill_q       <= '0;
            par_q        <= 1'b0;
            dw           <= '0;
            dw_vld       <= 1'b0;
            dw_be        <= '0;
            dw_last      <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            fill_q       <= fill_d;
            par_q        <= par_d;
            dw           <= dw_d;
            dw_vld       <= vld_d;
            dw_be        <= be_d;
            dw_last      <= last_d;
            protocol_err <= err_d;
        end
    end

endmodule

// File: tb/tb_csi2tx_yuv420_p2b_gen.sv
// Bench for csi2tx_yuv420_p2b_gen: 4- and 8-byte instances driven in parallel,
// checked against a byte-stream reference model through a scoreboard.
module tb_csi2tx_yuv420_p2b_gen;

    logic        clk;
    logic        rst_n;
    logic [31:0] pixel_data;
    logic        pixel_data_vld, line_start, line_end, line_odd, mode, convrn_enable;

    logic [31:0] dw4;
    logic        vld4, last4, err4;
    logic [3:0]  be4;
    logic [63:0] dw8;
    logic        vld8, last8, err8;
    logic [7:0]  be8;

    csi2tx_yuv420_p2b_gen #(.DW_BYTES(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .pixel_data(pixel_data), .pixel_data_vld(pixel_data_vld),
        .line_start(line_start), .line_end(line_end), .line_odd(line_odd), .mode(mode),
        .convrn_enable(convrn_enable), .dw(dw4), .dw_vld(vld4), .dw_be(be4),
        .dw_last(last4), .protocol_err(err4)
    );

    csi2tx_yuv420_p2b_gen #(.DW_BYTES(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .pixel_data(pixel_data), .pixel_data_vld(pixel_data_vld),
        .line_start(line_start), .line_end(line_end), .line_odd(line_odd), .mode(mode),
        .convrn_enable(convrn_enable), .dw(dw8), .dw_vld(vld8), .dw_be(be8),
        .dw_last(last8), .protocol_err(err8)
    );

    typedef struct {
        logic [63:0] data;
        logic [7:0]  be;
        logic        last;
    } exp_t;

    exp_t       expq[2][$];
    logic [7:0] bq[2][$];
    int         pidx;
    int         errors, checks;
    int         err_exp, err_seen4, err_seen8;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Stream bytes of one pixel, straight from the format table.
    function automatic void pix_bytes(input logic [31:0] pd, input logic md, input logic odd,
                                      input int p, output int n, output logic [7:0] c0,
                                      output logic [7:0] c1);
        logic [7:0] y, u, v;
        y  = pd[27:20];
        u  = pd[17:10];
        v  = pd[7:0];
        n  = 1;
        c0 = y;
        c1 = y;
        if (!md) begin
            if (p % 2 == 0) begin
                n  = 2;
                c0 = odd ? u : v;
            end
        end else if (!odd) begin
            n  = 2;
            c0 = (p % 2 == 0) ? u : v;
        end
    endfunction

    function automatic logic [31:0] pix(input int y, input int u, input int v);
        return 32'(((y & 255) << 20) | ((u & 255) << 10) | (v & 255));
    endfunction

    // Cut the byte stream of instance i into w-byte words.
    task automatic drain(input int i, input int w, input bit le);
        exp_t e;
        int   n;
        while (bq[i].size() >= w) begin
            e.data = '0;
            for (int k = 0; k < w; k++) e.data[8*k +: 8] = bq[i].pop_front();
            e.be   = 8'((1 << w) - 1);
            e.last = le && (bq[i].size() == 0);
            expq[i].push_back(e);
        end
        if (le && bq[i].size() > 0) begin
            n      = bq[i].size();
            e.data = '0;
            for (int k = 0; k < n; k++) e.data[8*k +: 8] = bq[i].pop_front();
            e.be   = 8'((1 << n) - 1);
            e.last = 1'b1;
            expq[i].push_back(e);
        end
    endtask

    task automatic model_clear();
        bq[0].delete();
        bq[1].delete();
        pidx = 0;
    endtask

    task automatic model_accept(input logic [31:0] pd, input bit le);
        int         n;
        logic [7:0] c0, c1;
        pix_bytes(pd, mode, line_odd, pidx, n, c0, c1);
        pidx++;
        for (int i = 0; i < 2; i++) begin
            bq[i].push_back(c0);
            if (n == 2) bq[i].push_back(c1);
            drain(i, (i == 0) ? 4 : 8, le);
        end
    endtask

    task automatic step(input logic v, input logic [31:0] pd, input logic ls, input logic le,
                        input logic en);
        pixel_data_vld = v;
        pixel_data     = pd;
        line_start     = ls;
        line_end       = le;
        convrn_enable  = en;
        @(posedge clk);
        #1;
        pixel_data_vld = 1'b0;
        line_start     = 1'b0;
        line_end       = 1'b0;
        convrn_enable  = 1'b1;
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic send_ls();
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        model_clear();
    endtask

    task automatic send_pix(input logic [31:0] pd, input bit le);
        step(1'b1, pd, 1'b0, le, 1'b1);
        model_accept(pd, le);
    endtask

    task automatic send_le();
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        drain(0, 4, 1'b1);
        drain(1, 8, 1'b1);
    endtask

    task automatic do_line(input logic md, input logic odd, input int npix, input bit le_last);
        mode     = md;
        line_odd = odd;
        send_ls();
        for (int p = 0; p < npix; p++) begin
            if ($urandom_range(0, 3) == 0) idle();
            send_pix($urandom, le_last && (p == npix - 1));
        end
        if (!le_last) begin
            repeat ($urandom_range(0, 2)) idle();
            send_le();
        end
        idle();
    endtask

    task automatic mon_word(input int i, input logic [63:0] d, input logic [7:0] be,
                            input logic last);
        exp_t  e;
        string nm;
        nm = (i == 0) ? "dw4" : "dw8";
        if (expq[i].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s unexpected word: got %h be %h, expected none", nm, d, be);
        end else begin
            e = expq[i].pop_front();
            check({nm, " data"}, d, e.data);
            check({nm, " be"}, 64'(be), 64'(e.be));
            check({nm, " last"}, 64'(last), 64'(e.last));
        end
    endtask

    // Scoreboard monitor, sampling mid-cycle.
    always @(negedge clk) begin
        if (vld4) mon_word(0, 64'(dw4), 8'(be4), last4);
        if (vld8) mon_word(1, dw8, be8, last8);
        if (err4) err_seen4++;
        if (err8) err_seen8++;
    end

    initial begin
        errors = 0; checks = 0; err_exp = 0; err_seen4 = 0; err_seen8 = 0; pidx = 0;
        rst_n = 1'b0; pixel_data = '0; pixel_data_vld = 1'b0; line_start = 1'b0;
        line_end = 1'b0; line_odd = 1'b1; mode = 1'b0; convrn_enable = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset dw4", 64'(dw4), 64'h0);
        check("reset vld4", 64'(vld4), 64'h0);
        check("reset be4", 64'(be4), 64'h0);
        check("reset last4", 64'(last4), 64'h0);
        check("reset err4", 64'(err4), 64'h0);
        check("reset dw8", dw8, 64'h0);
        check("reset vld8", 64'(vld8), 64'h0);
        check("reset be8", 64'(be8), 64'h0);
        check("reset last8", 64'(last8), 64'h0);
        check("reset err8", 64'(err8), 64'h0);
        rst_n = 1'b1;
        idle();

        // Legacy odd line, line_end later on its own.
        mode = 1'b0; line_odd = 1'b1;
        send_ls();
        for (int p = 0; p < 3; p++) send_pix(pix(8'h10 + p, 8'hA0 + p, 8'h50 + p), 1'b0);
        check("t1 word0 dw4", 64'(dw4), 64'hA21110A0);
        check("t1 word0 vld4", 64'(vld4), 64'h1);
        for (int p = 3; p < 5; p++) send_pix(pix(8'h10 + p, 8'hA0 + p, 8'h50 + p), 1'b0);
        check("t1 word1 dw4", 64'(dw4), 64'h14A41312);
        check("t1 word1 last4", 64'(last4), 64'h0);
        check("t1 word dw8", dw8, 64'h14A41312A21110A0);
        idle();
        send_le();
        idle();

        // Legacy even line ending with p2, then a pixel during the flush.
        mode = 1'b0; line_odd = 1'b0;
        send_ls();
        for (int p = 0; p < 3; p++) send_pix(pix(8'h10 + p, 8'hA0 + p, 8'h50 + p), p == 2);
        check("t2 full dw4", 64'(dw4), 64'h52111050);
        check("t2 full last4", 64'(last4), 64'h0);
        step(1'b1, pix(8'h77, 8'h77, 8'h77), 1'b0, 1'b0, 1'b1);
        err_exp++;
        check("t2 part dw4", 64'(dw4), 64'h12);
        check("t2 part be4", 64'(be4), 64'h1);
        check("t2 part last4", 64'(last4), 64'h1);
        check("t6 err4 pulse", 64'(err4), 64'h1);
        check("t2 part dw8", dw8, 64'h0000001252111050);
        check("t2 part be8", 64'(be8), 64'h1F);
        idle();
        check("t6 err4 one cycle", 64'(err4), 64'h0);
        idle();

        // Mode 1 even line, last pixel fills a word exactly.
        mode = 1'b1; line_odd = 1'b0;
        send_ls();
        for (int p = 0; p < 2; p++) send_pix(pix(8'h10 + p, 8'hA0 + p, 8'h50 + p), 1'b0);
        check("t3 word0 dw4", 64'(dw4), 64'h115110A0);
        for (int p = 2; p < 4; p++) send_pix(pix(8'h10 + p, 8'hA0 + p, 8'h50 + p), p == 3);
        check("t3 word1 dw4", 64'(dw4), 64'h135312A2);
        check("t3 word1 last4", 64'(last4), 64'h1);
        check("t3 word dw8", dw8, 64'h135312A2115110A0);
        check("t3 word last8", 64'(last8), 64'h1);
        idle();
        idle();

        // Enable dropped mid-line; the next line starts again at lane 0.
        mode = 1'b0; line_odd = 1'b1;
        send_ls();
        for (int p = 0; p < 2; p++) send_pix(pix(8'h10 + p, 8'hA0 + p, 8'h50 + p), 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        model_clear();
        check("t5 vld4 after disable", 64'(vld4), 64'h0);
        idle();
        send_ls();
        for (int p = 0; p < 3; p++) send_pix(pix(8'h20 + p, 8'hB0 + p, 8'h60 + p), 1'b0);
        check("t5 restart dw4", 64'(dw4), 64'hB22120B0);
        send_le();
        idle();

        // Reset asserted while a word is on the outputs.
        send_ls();
        for (int p = 0; p < 3; p++) send_pix(pix(8'h30 + p, 8'hC0 + p, 8'h40 + p), 1'b0);
        check("t6 pre-reset vld4", 64'(vld4), 64'h1);
        rst_n = 1'b0;
        #1;
        check("t6 rst dw4", 64'(dw4), 64'h0);
        check("t6 rst vld4", 64'(vld4), 64'h0);
        check("t6 rst be4", 64'(be4), 64'h0);
        check("t6 rst last4", 64'(last4), 64'h0);
        check("t6 rst dw8", dw8, 64'h0);
        expq[0].delete();
        expq[1].delete();
        model_clear();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle();

        // Random lines against the model.
        for (int l = 0; l < 40; l++) begin
            do_line(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom_range(1, 20), bit'($urandom_range(0, 1)));
        end

        repeat (4) idle();
        check("dw4 words outstanding", 64'(expq[0].size()), 64'h0);
        check("dw8 words outstanding", 64'(expq[1].size()), 64'h0);
        check("err4 pulse count", 64'(err_seen4), 64'(err_exp));
        check("err8 pulse count", 64'(err_seen8), 64'(err_exp));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
